// File: rtl/ristretto_mem_stage.sv
// ristretto_mem_stage: load/store memory stage with dmem request/response handshake.
// Define RISTRETTO_MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating them.
module ristretto_mem_stage #(
   parameter int AddrWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_op_i,
   input  logic [1:0]           req_size_i,
   input  logic                 req_unsigned_n_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [31:0]          req_wdata_i,
   input  logic [4:0]           req_rd_i,
   output logic                 dmem_req_valid_o,
   input  logic                 dmem_req_ready_i,
   output logic                 dmem_we_o,
   output logic [AddrWidth-1:0] dmem_addr_o,
   output logic [3:0]           dmem_be_o,
   output logic [31:0]          dmem_wdata_o,
   input  logic                 dmem_rsp_valid_i,
   output logic                 dmem_rsp_ready_o,
   input  logic [31:0]          dmem_rsp_rdata_i,
   output logic                 wb_valid_o,
   output logic [4:0]           wb_rd_o,
   output logic [31:0]          wb_data_o,
   output logic                 done_o,
   output logic                 misaligned_o,
   output logic                 misaligned_store_o
);
   typedef enum logic [1:0] {IDLE = 2'b00, WRDY = 2'b01, WVLD = 2'b10} state_t;
   state_t r_state;
   logic r_op, r_sn, r_done, r_wb_valid, r_mis, r_mis_st;
   logic [1:0] r_size;
   logic [AddrWidth-1:0] r_addr;
   logic [4:0] r_rd, r_wb_rd;
   logic [31:0] r_wdata, r_wb_data;
   logic [3:0] r_be;
   logic w_acc, w_mis;
   logic [1:0] w_off;
   logic [3:0] w_be;
   logic [31:0] w_wdata, w_lane, w_ld;
   assign req_ready_o = r_state == IDLE;
   assign w_acc = req_valid_i && req_ready_o && req_size_i != 2'b00;
`ifdef RISTRETTO_MEM_MISALIGN_TRAP_EN
   assign w_mis = (req_size_i == 2'b10 && req_addr_i[0]) || (req_size_i == 2'b01 && req_addr_i[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif
   // Lane offset with the address truncated to the access size
   assign w_off = req_size_i == 2'b01 ? 2'b00 : req_size_i == 2'b10 ? {req_addr_i[1], 1'b0} : req_addr_i[1:0];
   assign w_be = req_size_i == 2'b01 ? 4'b1111 : req_size_i == 2'b10 ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << w_off;
   assign w_wdata = req_size_i == 2'b01 ? req_wdata_i : req_size_i == 2'b10 ? {2{req_wdata_i[15:0]}} : {4{req_wdata_i[7:0]}};
   assign w_lane = dmem_rsp_rdata_i >> {r_addr[1:0], 3'b000};
   assign w_ld = r_size == 2'b01 ? w_lane :
                 r_size == 2'b10 ? {{16{r_sn & w_lane[15]}}, w_lane[15:0]} :
                                   {{24{r_sn & w_lane[7]}}, w_lane[7:0]};
   assign dmem_req_valid_o = r_state == WRDY;
   assign dmem_rsp_ready_o = r_state != WRDY;
   assign dmem_we_o = r_op;
   assign dmem_addr_o = {r_addr[AddrWidth-1:2], 2'b00};
   assign dmem_be_o = r_be;
   assign dmem_wdata_o = r_wdata;
   assign wb_valid_o = r_wb_valid;
   assign wb_rd_o = r_wb_rd;
   assign wb_data_o = r_wb_data;
   assign done_o = r_done;
   assign misaligned_o = r_mis;
   assign misaligned_store_o = r_mis_st;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_op <= 1'b0;
         r_sn <= 1'b0;
         r_size <= 2'b00;
         r_addr <= '0;
         r_rd <= 5'd0;
         r_wdata <= 32'd0;
         r_be <= 4'd0;
         r_done <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_rd <= 5'd0;
         r_wb_data <= 32'd0;
         r_mis <= 1'b0;
         r_mis_st <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wb_valid <= 1'b0;
         r_mis <= 1'b0;
         r_mis_st <= 1'b0;
         if (w_acc && w_mis) begin
            r_mis <= 1'b1;
            r_mis_st <= req_op_i;
         end else if (w_acc) begin
            r_state <= WRDY;
            r_op <= req_op_i;
            r_sn <= req_unsigned_n_i;
            r_size <= req_size_i;
            r_addr <= {req_addr_i[AddrWidth-1:2], w_off};
            r_rd <= req_rd_i;
            r_wdata <= w_wdata;
            r_be <= w_be;
         end else if (r_state == WRDY && dmem_req_ready_i) begin
            r_state <= WVLD;
         end else if (r_state == WVLD && dmem_rsp_valid_i) begin
            r_state <= IDLE;
            r_done <= 1'b1;
            if (!r_op) begin
               r_wb_valid <= 1'b1;
               r_wb_rd <= r_rd;
               r_wb_data <= w_ld;
            end
         end
      end
   end
endmodule

// File: tb/tb_ristretto_mem_stage.sv
// tb_ristretto_mem_stage: directed stimulus with scoreboard queues for dmem requests and completions.
module tb_ristretto_mem_stage;
   logic clk = 1'b0, rst = 1'b1;
   logic req_valid = 1'b0, req_op = 1'b0, req_sn = 1'b0;
   logic [1:0] req_size = 2'b00;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
   logic [4:0] req_rd = 5'd0;
   logic dreq_ready = 1'b0, rsp_valid = 1'b0;
   logic [31:0] rsp_rdata = 32'd0;
   logic req_ready, dreq_valid, dwe, rsp_ready, wb_valid, done, mis, mis_st;
   logic [31:0] daddr, dwdata, wb_data;
   logic [3:0] dbe;
   logic [4:0] wb_rd;
   int n_cmp = 0, n_err = 0;

   typedef struct packed {logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wd;} dreq_t;
   typedef struct packed {logic done; logic wbv; logic mis; logic mis_st; logic [4:0] rd; logic [31:0] data;} cpl_t;
   dreq_t dq[$];
   cpl_t cq[$];

   ristretto_mem_stage #(.AddrWidth(32)) dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_size_i(req_size), .req_unsigned_n_i(req_sn),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_rd_i(req_rd),
      .dmem_req_valid_o(dreq_valid), .dmem_req_ready_i(dreq_ready), .dmem_we_o(dwe),
      .dmem_addr_o(daddr), .dmem_be_o(dbe), .dmem_wdata_o(dwdata),
      .dmem_rsp_valid_i(rsp_valid), .dmem_rsp_ready_o(rsp_ready), .dmem_rsp_rdata_i(rsp_rdata),
      .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
      .done_o(done), .misaligned_o(mis), .misaligned_store_o(mis_st)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitors: compare DUT outputs against queued expectations whenever they appear
   always @(negedge clk) begin
      if (dreq_valid && dreq_ready) begin
         if (dq.size() == 0) chk("unexpected_dmem_req", 1'b1, 1'b0);
         else begin
            dreq_t e;
            e = dq.pop_front();
            chk("dmem_req", {daddr, dwe, dbe, dwdata}, e);
         end
      end
      if (done || wb_valid || mis) begin
         if (cq.size() == 0) chk("unexpected_completion", {done, wb_valid, mis}, 3'b000);
         else begin
            cpl_t c;
            c = cq.pop_front();
            chk("completion_flags", {done, wb_valid, mis, mis_st}, {c.done, c.wbv, c.mis, c.mis_st});
            if (c.wbv) chk("writeback", {wb_rd, wb_data}, {c.rd, c.data});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic issue(input logic op, input logic [1:0] sz, input logic sn, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd, input int stall, input logic [31:0] rdata,
                        input logic acc, input logic emis, input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_wb);
      if (acc) dq.push_back({e_addr, op, e_be, e_wd});
      if (acc || emis) cq.push_back({acc, acc & ~op, emis, emis & op, rd, e_wb});
      req_valid = 1'b1; req_op = op; req_size = sz; req_sn = sn; req_addr = addr; req_wdata = wd; req_rd = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (!acc) begin
         chk("no_access_req_valid", {dreq_valid, req_ready}, 2'b01);
         chk("trap_pulse", {mis, mis_st, done}, {emis, emis & op, 1'b0});
         @(posedge clk); #1;
         chk("trap_pulse_end", {mis, done, dreq_valid}, 3'b000);
         return;
      end
      chk("dmem_valid_n1", {dreq_valid, req_ready, rsp_ready}, 3'b100);
      for (int i = 0; i < stall; i++) begin
         chk("stall_hold", {dreq_valid, req_ready, daddr, dbe, dwdata}, {2'b10, e_addr, e_be, e_wd});
         @(posedge clk); #1;
      end
      dreq_ready = 1'b1;
      @(posedge clk); #1;
      dreq_ready = 1'b0;
      chk("wvld_state", {dreq_valid, rsp_ready, done}, 3'b010);
      rsp_valid = 1'b1; rsp_rdata = rdata;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      chk("done_latency", {done, wb_valid, req_ready}, {1'b1, ~op, 1'b1});
      @(posedge clk); #1;
      chk("done_pulse_end", {done, wb_valid}, 2'b00);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_state", {req_ready, dreq_valid, dwe, daddr, dbe, dwdata, rsp_ready, wb_valid, wb_rd, wb_data, done, mis, mis_st},
          {1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 3'b000});
      // signed byte load from lane 3
      issue(0, 2'b11, 1, 32'h103, 32'h0, 5'd5, 0, 32'h80FF_FF7F, 1, 0, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      // half store to upper half, then writeback registers must hold
      issue(1, 2'b10, 0, 32'h202, 32'h1234_ABCD, 5'd7, 0, 32'h0, 1, 0, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0);
      chk("wb_hold", {wb_rd, wb_data}, {5'd5, 32'hFFFF_FF80});
      issue(1, 2'b11, 0, 32'h003, 32'h0000_00AB, 5'd1, 0, 32'h0, 1, 0, 32'h000, 4'b1000, 32'hABAB_ABAB, 32'h0);
      issue(0, 2'b10, 1, 32'h006, 32'h0, 5'd9, 0, 32'h8001_7FFF, 1, 0, 32'h004, 4'b1100, 32'h0, 32'hFFFF_8001);
      issue(0, 2'b10, 0, 32'h002, 32'h0, 5'd10, 0, 32'h8001_7FFF, 1, 0, 32'h000, 4'b1100, 32'h0, 32'h0000_8001);
      issue(0, 2'b10, 1, 32'h010, 32'h0, 5'd11, 0, 32'h8001_7FFF, 1, 0, 32'h010, 4'b0011, 32'h0, 32'h0000_7FFF);
      issue(0, 2'b11, 0, 32'h101, 32'h0, 5'd12, 0, 32'h0000_9900, 1, 0, 32'h100, 4'b0010, 32'h0, 32'h0000_0099);
      // word load with dmem not ready for three cycles
      issue(0, 2'b01, 0, 32'h400, 32'h0, 5'd13, 3, 32'hDEAD_BEEF, 1, 0, 32'h400, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      // size none: ignored
      issue(0, 2'b00, 0, 32'h600, 32'h0, 5'd14, 0, 32'h0, 0, 0, 32'h0, 4'b0, 32'h0, 32'h0);
`ifdef RISTRETTO_MEM_MISALIGN_TRAP_EN
      issue(0, 2'b01, 1, 32'h301, 32'h0, 5'd15, 0, 32'h1122_3344, 0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
      issue(1, 2'b10, 0, 32'h205, 32'h0000_5A5A, 5'd16, 0, 32'h0, 0, 1, 32'h0, 4'b0, 32'h0, 32'h0);
`else
      issue(0, 2'b01, 1, 32'h301, 32'h0, 5'd15, 0, 32'h1122_3344, 1, 0, 32'h300, 4'b1111, 32'h0, 32'h1122_3344);
      issue(1, 2'b10, 0, 32'h205, 32'h0000_5A5A, 5'd16, 0, 32'h0, 1, 0, 32'h204, 4'b0011, 32'h5A5A_5A5A, 32'h0);
`endif
      // reset while waiting for the response, then a stale response in IDLE
      dq.push_back({32'h500, 1'b0, 4'b1111, 32'h0});
      req_valid = 1'b1; req_op = 0; req_size = 2'b01; req_sn = 0; req_addr = 32'h500; req_wdata = 32'h0; req_rd = 5'd17;
      @(posedge clk); #1;
      req_valid = 1'b0; dreq_ready = 1'b1;
      @(posedge clk); #1;
      dreq_ready = 1'b0; rst = 1'b1;
      chk("pre_reset_wvld", {dreq_valid, rsp_ready}, 2'b01);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_reset_idle", {req_ready, rsp_ready, done, wb_valid, wb_data}, {4'b1100, 32'h0});
      rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_0BAD;
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      chk("stale_rsp_drained", {done, wb_valid, req_ready, wb_data}, {3'b001, 32'h0});
      issue(0, 2'b11, 1, 32'h702, 32'h0, 5'd18, 0, 32'h0042_0000, 1, 0, 32'h700, 4'b0100, 32'h0, 32'h0000_0042);
      repeat (2) @(posedge clk);
      chk("dmem_queue_empty", dq.size(), 0);
      chk("cpl_queue_empty", cq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ristretto_mem_stage.md
RISTRETTO_MEM_STAGE -- requirements
Module: ristretto_mem_stage

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, byte address width of req_addr_i and dmem_addr_o.
REQ-002 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid_i input 1 and req_ready_o output 1: request handshake from the execution stage.
REQ-005 SHALL have port req_op_i  input  1  0 = load (MEM_LOAD_OP), 1 = store (MEM_STORE_OP).
REQ-006 SHALL have port req_size_i  input  2  01 word, 10 half, 11 byte, 00 none.
REQ-007 SHALL have port req_unsigned_n_i  input  1  1 = sign-extend load data, 0 = zero-extend.
REQ-008 SHALL have ports req_addr_i input AddrWidth, req_wdata_i input 32, req_rd_i input 5: byte address, store data, load destination register.
REQ-009 SHALL have ports dmem_req_valid_o output 1, dmem_req_ready_i input 1, dmem_we_o output 1, dmem_addr_o output AddrWidth (word-aligned), dmem_be_o output 4, dmem_wdata_o output 32.
REQ-010 SHALL have ports dmem_rsp_valid_i input 1, dmem_rsp_ready_o output 1, dmem_rsp_rdata_i input 32.
REQ-011 SHALL have ports wb_valid_o output 1, wb_rd_o output 5, wb_data_o output 32: registered load writeback.
REQ-012 SHALL have ports done_o output 1 (one-cycle completion pulse) and misaligned_o output 1 (one-cycle trap pulse), misaligned_store_o output 1 (qualifies misaligned_o: 1 = store).

Function
REQ-013 SHALL implement FSM states IDLE (00), WRDY (01, wait dmem ready), WVLD (10, wait dmem response).
REQ-014 SHALL assert req_ready_o combinationally iff state = IDLE; a request is accepted on req_valid_i && req_ready_o.
REQ-015 SHALL ignore accepted requests with req_size_i = 00 (no dmem access, no pulses, stay IDLE).
REQ-016 SHALL, on acceptance of a valid aligned request, register op/size/sign/addr/rd and formatted data and go to WRDY; dmem_req_valid_o is high exactly while in WRDY.
REQ-017 SHALL drive dmem_addr_o = {addr[AddrWidth-1:2], 2'b00}; dmem_we_o = op; payload stable while in WRDY.
REQ-018 SHALL set dmem_be_o: word 1111; half 0011 (addr[1]=0) or 1100; byte 1 << addr[1:0]; loads drive same mask.
REQ-019 SHALL replicate store data: half {2{wdata[15:0]}}, byte {4{wdata[7:0]}}, word unchanged.
REQ-020 SHALL move WRDY -> WVLD on dmem_req_valid_o && dmem_req_ready_i.
REQ-021 SHALL assert dmem_rsp_ready_o in WVLD and IDLE; responses in IDLE are discarded (drain after reset); responses in WRDY are not accepted.
REQ-022 SHALL, on response handshake in WVLD, go to IDLE and, in the next cycle, pulse done_o; for loads also pulse wb_valid_o with wb_rd_o and extracted data.
REQ-023 SHALL extract load data from lane addr[1:0] (byte) or addr[1] (half), sign- or zero-extended per req_unsigned_n_i.
REQ-024 SHALL give minimum latency: accept cycle N, dmem request N+1, response N+2, done_o/wb_valid_o N+3.
REQ-025 SHALL hold wb_data_o/wb_rd_o at last value when wb_valid_o = 0.

Reset
REQ-026 SHALL, when rst_i = 1 at a clock edge, enter IDLE and clear all outputs and registers to 0, including mid-transaction (outstanding request abandoned, no done_o/wb_valid_o).
REQ-027 SHALL give reset priority over any simultaneous handshake.

Configuration
REQ-028 SHALL honour macro RISTRETTO_MEM_MISALIGN_TRAP_EN.
REQ-029 SHALL, with the macro defined, treat half with addr[0]=1 or word with addr[1:0]!=00 as misaligned: accept, no dmem access, pulse misaligned_o (misaligned_store_o = op) next cycle, stay IDLE.
REQ-030 SHALL, without the macro, force misaligned_o/misaligned_store_o to 0 and truncate address (half: addr[0]=0, word: addr[1:0]=00) before access.

Verification
REQ-031 SHALL cover: load byte addr 0x103, signed, rdata 0x80FF_FF7F -> dmem_addr 0x100, be 1000, wb_data 0xFFFF_FF80, wb_valid at N+3 with ready/rsp immediate.
REQ-032 SHALL cover: store half addr 0x202 wdata 0x1234_ABCD -> dmem_we 1, be 1100, wdata 0xABCD_ABCD, done_o, no wb_valid.
REQ-033 SHALL cover: dmem_req_ready_i low 3 cycles -> dmem_req_valid_o held 4 cycles, payload stable, req_ready_o 0 throughout.
REQ-034 SHALL cover: word load addr 0x301 with macro -> misaligned_o pulse, no dmem_req_valid_o; without macro -> access at 0x300, be 1111.
REQ-035 SHALL cover: rst_i in WVLD, then stale dmem_rsp_valid_i -> response drained, no done_o/wb_valid_o, next request served normally.
